// File: rtl/ring_game_pkg.sv
// Shared types and helpers for the ring reaction game: FSM states, legal ring
// positions and two-digit BCD arithmetic.
package ring_game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_OVER = 2'd3
   } state_e;

   localparam logic [14:0] RING_LEGAL_MASK = 15'b010_0100_1001_0010;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t hi;
      bcd_digit_t lo;
   } bcd2_t;

   // Exactly one bit set, and that bit is one of the five ring stops.
   function automatic logic ring_legal(input logic [14:0] r);
      return (r != '0) && ((r & (r - 15'd1)) == '0) && ((r & ~RING_LEGAL_MASK) == '0);
   endfunction

   function automatic bcd2_t bcd_inc_sat(input bcd2_t s);
      bcd2_t r;
      r = s;
      if (s.hi == 4'd9 && s.lo == 4'd9) begin
         r = s;
      end else if (s.lo == 4'd9) begin
         r.lo = 4'd0;
         r.hi = s.hi + 4'd1;
      end else begin
         r.lo = s.lo + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for the raw button plus rising-edge detect. A level
// already high when reset releases is not reported as a press.
module btn_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic rise_o
);

   logic       s1_q, s2_q, prev_q;
   logic [1:0] vld_q;

   // prev_q holds high until the synchronizer carries a post-reset sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b1;
         vld_q  <= 2'b00;
      end else begin
         s1_q   <= btn_i;
         s2_q   <= s1_q;
         vld_q  <= {vld_q[0], 1'b1};
         prev_q <= vld_q[1] ? s2_q : 1'b1;
      end
   end

   assign rise_o = vld_q[1] & s2_q & ~prev_q;

endmodule

// File: rtl/ring_hit_judge.sv
// Reaction game judge: paces the ring counter, scores button presses against
// the target stop. Optional HIT_SPEEDUP_EN shortens the step period per hit.
module ring_hit_judge #(
   parameter int unsigned TICK_DIV   = 25_000_000,
   parameter int unsigned TARGET_BIT = 7,
   parameter int unsigned LIVES_INIT = 3,
   parameter int unsigned HOLD_CYC   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [14:0] ring,
   input  logic        btn,
   output logic        step,
   output logic [7:0]  score_bcd,
   output logic [1:0]  lives,
   output logic        hit_pulse,
   output logic        miss_pulse,
   output logic        game_over,
   output logic        ring_err
);
   import ring_game_pkg::*;

   localparam int unsigned CW     = $clog2(TICK_DIV + 1);
   localparam int unsigned HW     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [1:0]  LIVES0 = 2'(LIVES_INIT);

   state_e        state_q, state_d;
   logic [CW-1:0] tick_q, tick_d;
   logic [HW-1:0] hold_q, hold_d;
   bcd2_t         score_q, score_d;
   logic [1:0]    lives_q, lives_d;
   logic          hit_q, hit_d, miss_q, miss_d, err_q;
   logic          btn_rise, legal, hit, tick_last;
   logic [CW-1:0] period;

   btn_sync_edge u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn),
      .rise_o (btn_rise)
   );

   assign legal = ring_legal(ring);
   assign hit   = legal && ring[TARGET_BIT];

`ifdef HIT_SPEEDUP_EN
   localparam logic [CW-1:0] PER_STEP = CW'(TICK_DIV >> 3);
   localparam logic [CW-1:0] PER_MIN  = CW'(TICK_DIV >> 2);
   logic [CW-1:0] period_q, period_d;

   always_comb begin
      period_d = period_q;
      if (state_q == ST_IDLE && btn_rise)
         period_d = CW'(TICK_DIV);
      else if (state_q == ST_RUN && btn_rise && hit)
         period_d = (period_q < PER_MIN + PER_STEP) ? PER_MIN : period_q - PER_STEP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) period_q <= CW'(TICK_DIV);
      else        period_q <= period_d;
   end

   assign period = period_q;
`else
   assign period = CW'(TICK_DIV);
`endif

   assign tick_last = (tick_q == period - 1'b1);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      hold_d  = hold_q;
      score_d = score_q;
      lives_d = lives_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      case (state_q)
         ST_IDLE: if (btn_rise) begin
            state_d = ST_RUN;
            score_d = '0;
            lives_d = LIVES0;
            tick_d  = '0;
         end
         // A press preempts the tick: judge now, restart the period afterwards
         ST_RUN: if (btn_rise) begin
            tick_d = '0;
            hold_d = '0;
            if (hit) begin
               hit_d   = 1'b1;
               score_d = bcd_inc_sat(score_q);
               state_d = ST_HOLD;
            end else begin
               miss_d  = 1'b1;
               lives_d = lives_q - 2'd1;
               state_d = (lives_q == 2'd1) ? ST_OVER : ST_HOLD;
            end
         end else begin
            tick_d = tick_last ? '0 : tick_q + 1'b1;
         end
         ST_HOLD: if (hold_q == HW'(HOLD_CYC - 1)) state_d = ST_RUN;
                  else hold_d = hold_q + 1'b1;
         ST_OVER: if (btn_rise) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         hold_q  <= '0;
         score_q <= '0;
         lives_q <= LIVES0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         hold_q  <= hold_d;
         score_q <= score_d;
         lives_q <= lives_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         err_q   <= err_q | ~legal;
      end
   end

   assign step       = (state_q == ST_RUN) && tick_last && !btn_rise;
   assign score_bcd  = score_q;
   assign lives      = lives_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;
   assign game_over  = (state_q == ST_OVER);
   assign ring_err   = err_q;

endmodule

// File: tb/tb_ring_hit_judge.sv
// Bench for ring_hit_judge: directed game scenarios plus random play, every
// cycle compared against an integer-level model of the game rules.
module tb_ring_hit_judge;
   localparam int TICK_DIV   = 8;
   localparam int HOLD_CYC   = 4;
   localparam int LIVES_INIT = 3;
   localparam int TARGET_BIT = 7;
   localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_OVER = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [14:0] ring  = 15'h0080;
   logic        btn   = 1'b0;
   logic        step, hit_pulse, miss_pulse, game_over, ring_err;
   logic [7:0]  score_bcd;
   logic [1:0]  lives;

   int n_vec = 0;
   int n_err = 0;

   int m_mode, m_score, m_lives, m_tick, m_hold;
   bit m_err, m_hit, m_miss, m_rise;
   bit samp[$];
   int lb[5] = '{1, 4, 7, 10, 13};

   ring_hit_judge #(
      .TICK_DIV   (TICK_DIV),
      .TARGET_BIT (TARGET_BIT),
      .LIVES_INIT (LIVES_INIT),
      .HOLD_CYC   (HOLD_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ring       (ring),
      .btn        (btn),
      .step       (step),
      .score_bcd  (score_bcd),
      .lives      (lives),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse),
      .game_over  (game_over),
      .ring_err   (ring_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      assert (act === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_score = 0; m_lives = LIVES_INIT; m_tick = 0; m_hold = 0;
      m_err = 1'b0; m_hit = 1'b0; m_miss = 1'b0; m_rise = 1'b0;
      samp.delete();
   endtask

   // One clock edge of the game rules, using the press seen before the edge.
   task automatic model_edge(input bit b, input logic [14:0] r);
      bit lg;
      lg = ($countones(r) == 1) && (r[1] || r[4] || r[7] || r[10] || r[13]);
      m_hit = 1'b0;
      m_miss = 1'b0;
      if (!lg) m_err = 1'b1;
      case (m_mode)
         M_IDLE: if (m_rise) begin
            m_mode = M_RUN; m_score = 0; m_lives = LIVES_INIT; m_tick = 0;
         end
         M_RUN: if (m_rise) begin
            m_tick = 0;
            if (lg && r[TARGET_BIT]) begin
               m_hit = 1'b1;
               m_score = (m_score >= 99) ? 99 : m_score + 1;
               m_mode = M_HOLD; m_hold = HOLD_CYC;
            end else begin
               m_miss = 1'b1;
               m_lives = m_lives - 1;
               if (m_lives == 0) m_mode = M_OVER;
               else begin m_mode = M_HOLD; m_hold = HOLD_CYC; end
            end
         end else begin
            m_tick = (m_tick + 1) % TICK_DIV;
         end
         M_HOLD: begin
            m_hold = m_hold - 1;
            if (m_hold == 0) m_mode = M_RUN;
         end
         default: if (m_rise) m_mode = M_IDLE;
      endcase
      // press seen after this edge: last two post-reset samples were low then high
      samp.push_back(b);
      if (samp.size() > 3) void'(samp.pop_front());
      m_rise = (samp.size() == 3) && samp[1] && !samp[0];
   endtask

   task automatic check_all();
      bit es;
      logic [7:0] sc;
      es = (m_mode == M_RUN) && (m_tick == TICK_DIV - 1) && !m_rise;
      sc = 8'((m_score / 10) * 16 + (m_score % 10));
      chk("step",       32'(step),       32'(es));
      chk("score_bcd",  32'(score_bcd),  32'(sc));
      chk("lives",      32'(lives),      32'(m_lives));
      chk("hit_pulse",  32'(hit_pulse),  32'(m_hit));
      chk("miss_pulse", 32'(miss_pulse), 32'(m_miss));
      chk("game_over",  32'(game_over),  32'(m_mode == M_OVER));
      chk("ring_err",   32'(ring_err),   32'(m_err));
   endtask

   task automatic cyc(input bit b, input logic [14:0] r);
      btn = b;
      ring = r;
      @(posedge clk);
      model_edge(b, r);
      #1;
      check_all();
   endtask

   // Ends on the cycle where the judgement strobe is visible.
   task automatic press(input logic [14:0] r);
      cyc(1'b1, r);
      cyc(1'b1, r);
      cyc(1'b0, r);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_step"},  32'(step),       32'd0);
      chk({tag, "_score"}, 32'(score_bcd),  32'h00);
      chk({tag, "_lives"}, 32'(lives),      32'(LIVES_INIT));
      chk({tag, "_hit"},   32'(hit_pulse),  32'd0);
      chk({tag, "_miss"},  32'(miss_pulse), 32'd0);
      chk({tag, "_over"},  32'(game_over),  32'd0);
      chk({tag, "_err"},   32'(ring_err),   32'd0);
   endtask

   function automatic logic [14:0] rand_ring();
      int k;
      logic [14:0] one;
      one = 15'h0001;
      k = $urandom_range(0, 9);
      case (k)
         0, 1, 2, 3, 4: return one << lb[k];
         5, 6:          return 15'h0080;
         7:             return 15'h0000;
         8:             return 15'h0081;
         default:       return 15'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int last;
      bit found;
      bit rb;
      logic [14:0] rr;

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("por");
      check_all();
      rst_n = 1'b1;
      repeat (3) cyc(1'b0, 15'h0080);

      // start a game and measure the step cadence
      press(15'h0080);
      chk("idle_to_run_lives", 32'(lives), 32'(LIVES_INIT));
      last = -1;
      for (int c = 0; c < 30; c++) begin
         cyc(1'b0, 15'h0080);
         if (step === 1'b1) begin
            if (last >= 0) chk("step_period", 32'(c - last), 32'(TICK_DIV));
            last = c;
         end
      end

      // hits up to saturation
      for (int k = 0; k < 100; k++) begin
         press(15'h0080);
         chk("hit_strobe", 32'(hit_pulse), 32'd1);
         if (k == 0)  chk("score_01", 32'(score_bcd), 32'h01);
         if (k == 9)  chk("score_10", 32'(score_bcd), 32'h10);
         if (k == 98) chk("score_99", 32'(score_bcd), 32'h99);
         if (k == 99) chk("score_sat", 32'(score_bcd), 32'h99);
         repeat (HOLD_CYC + $urandom_range(0, 5)) cyc(1'b0, 15'h0080);
      end

      // three misses end the game
      for (int k = 0; k < 3; k++) begin
         press(15'h0002);
         chk("miss_strobe", 32'(miss_pulse), 32'd1);
         chk("lives_dec", 32'(lives), 32'(2 - k));
         repeat (HOLD_CYC + 1) cyc(1'b0, 15'h0002);
      end
      chk("over_flag", 32'(game_over), 32'd1);
      for (int k = 0; k < 12; k++) begin
         cyc(1'b0, 15'h0002);
         chk("over_no_step", 32'(step), 32'd0);
      end
      press(15'h0002);
      chk("over_to_idle", 32'(game_over), 32'd0);

      // new game: illegal ring, sticky error, press on the tick cycle
      cyc(1'b0, 15'h0080);
      press(15'h0080);
      chk("err_clear", 32'(ring_err), 32'd0);
      cyc(1'b0, 15'h0080);
      press(15'h0081);
      chk("illegal_miss", 32'(miss_pulse), 32'd1);
      chk("illegal_err", 32'(ring_err), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_mode == M_RUN && m_tick == TICK_DIV - 3) found = 1'b1;
         else cyc(1'b0, 15'h0080);
      end
      if (!found) begin
         n_vec++;
         n_err++;
         $display("FAIL tick_search: observed no RUN tick %0d, required one within 40 cycles", TICK_DIV - 3);
      end
      cyc(1'b1, 15'h0080);
      cyc(1'b1, 15'h0080);
      chk("coincide_step", 32'(step), 32'd0);
      cyc(1'b0, 15'h0080);
      chk("coincide_hit", 32'(hit_pulse), 32'd1);
      for (int k = 0; k < 2; k++) begin
         repeat (HOLD_CYC + 1) cyc(1'b0, 15'h0002);
         press(15'h0002);
      end
      chk("over_again", 32'(game_over), 32'd1);
      cyc(1'b0, 15'h0080);
      press(15'h0080);
      chk("err_sticky_idle", 32'(ring_err), 32'd1);

      // reset in HOLD with the button held through release
      cyc(1'b0, 15'h0080);
      press(15'h0080);
      cyc(1'b0, 15'h0080);
      press(15'h0080);
      cyc(1'b1, 15'h0080);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("hold_rst");
      model_reset();
      check_all();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) cyc(1'b1, 15'h0080);
      chk("held_no_rise_step", 32'(step), 32'd0);
      chk("held_no_rise_score", 32'(score_bcd), 32'h00);
      cyc(1'b0, 15'h0080);

      // random play
      rb = 1'b0;
      rr = 15'h0080;
      repeat (600) begin
         if ($urandom_range(0, 3) == 0) rb = ~rb;
         if ($urandom_range(0, 2) == 0) rr = rand_ring();
         cyc(rb, rr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
